// File: rtl/prog_pkg.sv
// Shared types and widths for the fetch path: PC state encoding plus
// the address and lookup-pointer widths used by the LUT and decoder.
package prog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int PC_W  = 10;
    localparam int PTR_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports: clk, rst (async high), clr, en in; count out (CNT_W bits).
module sat_counter
    import prog_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/prog_counter.sv
// Program counter / fetch sequencer: Start/Done handshake, stall, halt,
// branch load from the LUT, and a saturating RUN-cycle counter.
// Ports: Clk, Reset, Start, StartAddr, Stall, Halt, BranchEn, BranchPtr,
// absaddress in; LutPointer, ProgCtr, Running, Done, CycleCount out.
module prog_counter
    import prog_pkg::*;
#(
    parameter int PC_W  = prog_pkg::PC_W,
    parameter int PTR_W = prog_pkg::PTR_W,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic [PTR_W-1:0] BranchPtr,
    output logic [PTR_W-1:0] LutPointer,
    input  logic [PC_W-1:0]  absaddress,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    pc_state_t       state_q;
    pc_state_t       state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            cnt_clr;
    logic            cnt_en;

    // The LUT sits beside this block; its answer is consumed same cycle.
    assign LutPointer = BranchPtr;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = StartAddr;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                // Stall cycles and the halt cycle both count.
                cnt_en = 1'b1;
                if (Stall) begin
                    pc_d = pc_q;
                end else if (Halt) begin
                    state_d = DONE;
                end else if (BranchEn) begin
                    pc_d = absaddress;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycles (
        .clk   (Clk),
        .rst   (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (CycleCount)
    );

    assign ProgCtr = pc_q;
    assign Running = (state_q == RUN);
    assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: reset, sequencing, branch, stall,
// wrap-around, restart from DONE and async reset mid-program.
module tb_prog_counter;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  StartAddr;
    logic        Stall;
    logic        Halt;
    logic        BranchEn;
    logic [3:0]  BranchPtr;
    logic [3:0]  LutPointer;
    logic [9:0]  absaddress;
    logic [9:0]  ProgCtr;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCount;

    int total;
    int bad;

    prog_counter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .Halt       (Halt),
        .BranchEn   (BranchEn),
        .BranchPtr  (BranchPtr),
        .LutPointer (LutPointer),
        .absaddress (absaddress),
        .ProgCtr    (ProgCtr),
        .Running    (Running),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic state_chk(input string tag, input logic [9:0] pc,
                             input logic run, input logic dn,
                             input logic [15:0] cnt);
        chk({tag, ".pc"}, 32'(ProgCtr), 32'(pc));
        chk({tag, ".run"}, 32'(Running), 32'(run));
        chk({tag, ".done"}, 32'(Done), 32'(dn));
        chk({tag, ".cnt"}, 32'(CycleCount), 32'(cnt));
    endtask

    task automatic start_at(input logic [9:0] a);
        Start = 1'b1;
        StartAddr = a;
        step();
        Start = 1'b0;
    endtask

    task automatic halt_now();
        Halt = 1'b1;
        step();
        Halt = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        Reset = 1'b1;
        Start = 1'b0;
        StartAddr = '0;
        Stall = 1'b0;
        Halt = 1'b0;
        BranchEn = 1'b0;
        BranchPtr = '0;
        absaddress = '0;
        #3;
        state_chk("reset", 10'd0, 1'b0, 1'b0, 16'd0);
        step();
        Reset = 1'b0;
        step();
        state_chk("idle_hold", 10'd0, 1'b0, 1'b0, 16'd0);

        // straight line 5,6,7,8 then halt
        start_at(10'd5);
        state_chk("seq0", 10'd5, 1'b1, 1'b0, 16'd0);
        step();
        chk("seq1.pc", 32'(ProgCtr), 32'd6);
        step();
        chk("seq2.pc", 32'(ProgCtr), 32'd7);
        step();
        state_chk("seq3", 10'd8, 1'b1, 1'b0, 16'd3);
        halt_now();
        state_chk("halt", 10'd8, 1'b0, 1'b1, 16'd4);
        step();
        state_chk("done_hold", 10'd8, 1'b0, 1'b1, 16'd4);

        // restart from DONE, then ignored Start in RUN
        start_at(10'd100);
        state_chk("restart", 10'd100, 1'b1, 1'b0, 16'd0);
        start_at(10'd500);
        state_chk("start_in_run", 10'd101, 1'b1, 1'b0, 16'd1);
        halt_now();

        // branch at PC 20 through LUT entry 9 -> 300
        start_at(10'd20);
        BranchEn = 1'b1;
        BranchPtr = 4'd9;
        absaddress = 10'd300;
        #1;
        chk("lutptr", 32'(LutPointer), 32'd9);
        step();
        BranchEn = 1'b0;
        absaddress = 10'd0;
        state_chk("branch", 10'd300, 1'b1, 1'b0, 16'd1);
        step();
        chk("branch_next.pc", 32'(ProgCtr), 32'd301);
        halt_now();

        // stall dominates halt and branch
        start_at(10'd12);
        Stall = 1'b1;
        Halt = 1'b1;
        BranchEn = 1'b1;
        absaddress = 10'd777;
        step();
        state_chk("stall1", 10'd12, 1'b1, 1'b0, 16'd1);
        step();
        state_chk("stall2", 10'd12, 1'b1, 1'b0, 16'd2);
        Stall = 1'b0;
        Halt = 1'b0;
        BranchEn = 1'b0;
        step();
        state_chk("unstall", 10'd13, 1'b1, 1'b0, 16'd3);
        halt_now();

        // address wrap-around
        start_at(10'd1022);
        chk("wrap0.pc", 32'(ProgCtr), 32'd1022);
        step();
        chk("wrap1.pc", 32'(ProgCtr), 32'd1023);
        step();
        chk("wrap2.pc", 32'(ProgCtr), 32'd0);
        step();
        chk("wrap3.pc", 32'(ProgCtr), 32'd1);
        halt_now();

        // async reset in RUN at PC 37
        start_at(10'd35);
        step();
        step();
        state_chk("pre_rst", 10'd37, 1'b1, 1'b0, 16'd2);
        #2;
        Reset = 1'b1;
        #1;
        state_chk("async_rst", 10'd0, 1'b0, 1'b0, 16'd0);
        step();
        Reset = 1'b0;
        step();
        step();
        state_chk("post_rst", 10'd0, 1'b0, 1'b0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
# prog_counter

Program-counter and fetch-sequencing stage that consumes the branch-target lookup table's absolute address output. Holds the 10-bit instruction address, steps it sequentially, and loads the absolute target on a taken branch. Runs a Start/Done handshake with the top level, supports decoder stalls and halts, and counts execution cycles for benchmarking.

## Interface
Parameters:
- PC_W, 10: instruction address width; matches the lookup table's absaddress width.
- PTR_W, 4: lookup table pointer width.
- CNT_W, 16: cycle counter width.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request to begin a program.
- StartAddr  in  PC_W  first instruction address; sampled with Start.
- Stall  in  1  decoder hold; the PC must not advance.
- Halt  in  1  the instruction at ProgCtr is a halt.
- BranchEn  in  1  the instruction at ProgCtr is a taken branch.
- BranchPtr  in  PTR_W  lookup table index from the instruction field.
- LutPointer  out  PTR_W  index to the lookup table.
- absaddress  in  PC_W  absolute target returned by the lookup table.
- ProgCtr  out  PC_W  current instruction address.
- Running  out  1  high while in RUN.
- Done  out  1  high while in DONE.
- CycleCount  out  CNT_W  number of RUN cycles in the current or most recent program.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - Start=1 → RUN. ProgCtr←StartAddr and CycleCount←0.
  - Otherwise all registers hold.
- RUN: CycleCount increments every cycle, including stall cycles, and saturates at 2^CNT_W−1. PC update priority is:
  1. Stall=1: ProgCtr holds. Halt and BranchEn are ignored this cycle.
  2. Halt=1: → DONE. ProgCtr holds at the halt address.
  3. BranchEn=1: ProgCtr←absaddress.
  4. Otherwise ProgCtr←ProgCtr+1, wrapping modulo 2^PC_W (1023→0).
- Start in RUN is ignored.
- DONE:
  - Done=1 and ProgCtr holds. CycleCount freezes so it can be read.
  - Start=1 → RUN with the same loads as in IDLE. Done drops the following cycle.
- LutPointer = BranchPtr, a combinational pass-through. The lookup table result is used in the same cycle.
- absaddress is used only when BranchEn=1 and the stage is in RUN without a stall.

## Timing
- Reset values: ProgCtr=0, Running=0, Done=0, CycleCount=0, state=IDLE. Reset is asynchronous, so outputs clear immediately without waiting for a clock edge.
- Reset asserted in any state aborts the program. No Done pulse is produced.
- Start sampled high at edge t: ProgCtr=StartAddr and Running=1 after t.
- Halt sampled at edge t while in RUN without a stall: Done=1 and Running=0 after t.
- CycleCount includes the halt cycle. For a program that is N straight-line instructions followed by a halt, with no stalls, CycleCount=N+1.
- Branch latency is one cycle. The target appears on ProgCtr after the edge where BranchEn was sampled.
- Combinational paths: BranchPtr→LutPointer, and absaddress→ProgCtr next-state. No other input-to-output combinational paths exist.
- Running and Done are never high together. In IDLE after reset, both are low.

## Structure
- Shared package prog_pkg holds:
  - typedef enum logic[1:0] {IDLE, RUN, DONE} pc_state_t
  - localparams PC_W=10 and PTR_W=4, shared with the lookup table and the decoder.
- One sub-module, sat_counter: CNT_W-bit saturating counter with clear and enable inputs, used for CycleCount.
- The lookup table is instantiated beside this block at the top level, not inside it.

## Test plan
- Reset mid-RUN at ProgCtr=37 → ProgCtr=0, Running=0, Done=0, CycleCount=0 immediately. A new Start is required to run again.
- Start with StartAddr=5, then 3 plain cycles, then Halt → ProgCtr sequence 5,6,7,8 and Done=1 with ProgCtr=8. CycleCount=4.
- BranchEn=1 with BranchPtr=9 at PC=20, lookup table returning 300 → LutPointer=9 and ProgCtr=300 next cycle. Then 301 on the following cycle.
- Stall=1 together with Halt=1 and BranchEn=1 for 2 cycles at PC=12 → ProgCtr holds at 12 and the stage stays in RUN. CycleCount still advances by 2.
- StartAddr=1022 with no branches → ProgCtr sequence 1022, 1023, 0, 1 (wrap-around).
- In DONE, pulse Start with StartAddr=100 → Done low next cycle, ProgCtr=100, CycleCount restarts at 0. A Start issued during RUN has no effect.
